// File: rtl/fetch_control_pkg.sv
// Shared definitions for the fetch-stage controller: data width, the NOP
// word injected on flushes and the controller FSM encoding.
package fetch_control_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN           = 2'd0,
        ST_MEM_WAIT      = 2'd1,
        ST_REDIRECT_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_control_sat_counter.sv
// Saturating up-counter: advances by one when inc_i is high and sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage pipeline controller: arbitrates PC updates and IF/ID, ID/EX
// flushes between branch redirects, load-use stalls and a busy instruction memory.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter int              CNT_W        = 16,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              imem_busy,
    input  logic              load_use_hazard,
    input  logic              branch_control,
    input  logic [XLEN-1:0]   branch_address,
    output logic              pc_write_en,
    output logic              pc_sel,
    output logic [XLEN-1:0]   redirect_address,
    output logic              if_id_write_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  redirect_count,
    output fetch_state_e      dbg_state_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;

    logic            pc_we_c, ifid_we_c, sel_c, iff_c, exf_c;
    logic [XLEN-1:0] addr_c;

    always_comb begin
        pc_we_c     = 1'b1;
        ifid_we_c   = 1'b1;
        sel_c       = 1'b0;
        iff_c       = 1'b0;
        exf_c       = 1'b0;
        addr_c      = branch_address;
        state_d     = state_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            ST_RUN: begin
                if (branch_control) begin
                    sel_c = 1'b1;
                    iff_c = 1'b1;
                    exf_c = 1'b1;
                end else if (load_use_hazard) begin
                    pc_we_c   = 1'b0;
                    ifid_we_c = 1'b0;
                    exf_c     = 1'b1;
                    if (imem_busy) state_d = ST_MEM_WAIT;
                end else if (imem_busy) begin
                    pc_we_c = 1'b0;
                    iff_c   = 1'b1;
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                // The PC cannot move while a fetch is outstanding, so the target is parked.
                if (branch_control) begin
                    pend_addr_d = branch_address;
                    pc_we_c     = 1'b0;
                    iff_c       = 1'b1;
                    exf_c       = 1'b1;
                    state_d     = ST_REDIRECT_HOLD;
                end else if (load_use_hazard) begin
                    pc_we_c   = 1'b0;
                    ifid_we_c = 1'b0;
                    exf_c     = 1'b1;
                    if (!imem_busy) state_d = ST_RUN;
                end else if (imem_busy) begin
                    pc_we_c = 1'b0;
                    iff_c   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT_HOLD: begin
                iff_c = 1'b1;
                exf_c = branch_control;
                if (imem_busy) begin
                    pc_we_c = 1'b0;
                    addr_c  = pend_addr_q;
                    if (branch_control) pend_addr_d = branch_address;
                end else begin
                    // A branch resolving this very cycle is younger than the parked one.
                    sel_c   = 1'b1;
                    addr_c  = branch_control ? branch_address : pend_addr_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_RUN;
            pend_addr_q <= RESET_VECTOR;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc_write_en      = RESET & pc_we_c;
    assign if_id_write_en   = RESET & ifid_we_c;
    assign pc_sel           = RESET & sel_c;
    assign if_id_flush      = ~RESET | iff_c;
    assign id_ex_flush      = ~RESET | exf_c;
    assign redirect_address = addr_c;
    assign dbg_state_o      = state_q;

    // Counters hold at zero through reset, so they can use the ungated controls.
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .inc_i   (~pc_we_c),
        .count_o (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .inc_i   (sel_c & pc_we_c),
        .count_o (redirect_count)
    );

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: a flag-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_control;
    import fetch_control_pkg::*;

    localparam int          CNT_W = 4;
    localparam logic [31:0] RV    = 32'h0000_0080;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             imem_busy = 1'b0;
    logic             load_use_hazard = 1'b0;
    logic             branch_control = 1'b0;
    logic [31:0]      branch_address = 32'h0;
    logic             pc_write_en, pc_sel, if_id_write_en, if_id_flush, id_ex_flush;
    logic [31:0]      redirect_address;
    logic [CNT_W-1:0] stall_cycles, redirect_count;
    fetch_state_e     dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    fetch_control #(.CNT_W(CNT_W), .RESET_VECTOR(RV)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .imem_busy        (imem_busy),
        .load_use_hazard  (load_use_hazard),
        .branch_control   (branch_control),
        .branch_address   (branch_address),
        .pc_write_en      (pc_write_en),
        .pc_sel           (pc_sel),
        .redirect_address (redirect_address),
        .if_id_write_en   (if_id_write_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .stall_cycles     (stall_cycles),
        .redirect_count   (redirect_count),
        .dbg_state_o      (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: "fetch outstanding" and "redirect parked" flags plus counts.
    bit          m_wait, m_pv;
    logic [31:0] m_pend;
    int          m_stall, m_redir;

    always @(negedge CLK) begin
        logic        e_pcwe, e_ifwe, e_sel, e_iff, e_exf;
        logic [31:0] e_addr;
        bit          n_wait, n_pv;
        logic [31:0] n_pend;
        if (!RESET) begin
            m_wait = 0; m_pv = 0; m_pend = RV; m_stall = 0; m_redir = 0;
            check("m_rst_pc_we", 32'(pc_write_en), 0);
            check("m_rst_ifid_we", 32'(if_id_write_en), 0);
            check("m_rst_if_flush", 32'(if_id_flush), 1);
            check("m_rst_ex_flush", 32'(id_ex_flush), 1);
            check("m_rst_pc_sel", 32'(pc_sel), 0);
            check("m_rst_stall", 32'(stall_cycles), 0);
            check("m_rst_redir", 32'(redirect_count), 0);
        end else begin
            e_pcwe = 1; e_ifwe = 1; e_sel = 0; e_iff = 0; e_exf = 0;
            e_addr = branch_address;
            n_wait = m_wait; n_pv = m_pv; n_pend = m_pend;
            if (m_pv) begin
                e_iff = 1;
                e_exf = branch_control;
                e_addr = (branch_control && !imem_busy) ? branch_address : m_pend;
                if (imem_busy) begin
                    e_pcwe = 0;
                    if (branch_control) n_pend = branch_address;
                end else begin
                    e_sel = 1; n_pv = 0; n_wait = 0;
                end
            end else if (branch_control) begin
                e_iff = 1; e_exf = 1;
                if (m_wait) begin
                    e_pcwe = 0; n_pv = 1; n_pend = branch_address;
                end else begin
                    e_sel = 1;
                end
            end else if (load_use_hazard) begin
                e_pcwe = 0; e_ifwe = 0; e_exf = 1; n_wait = imem_busy;
            end else if (imem_busy) begin
                e_pcwe = 0; e_iff = 1; n_wait = 1;
            end else begin
                n_wait = 0;
            end
            check("m_pc_we", 32'(pc_write_en), 32'(e_pcwe));
            check("m_ifid_we", 32'(if_id_write_en), 32'(e_ifwe));
            check("m_pc_sel", 32'(pc_sel), 32'(e_sel));
            check("m_if_flush", 32'(if_id_flush), 32'(e_iff));
            check("m_ex_flush", 32'(id_ex_flush), 32'(e_exf));
            check("m_redir_addr", redirect_address, e_addr);
            check("m_stall", 32'(stall_cycles), 32'(m_stall));
            check("m_redir_cnt", 32'(redirect_count), 32'(m_redir));
            if (!e_pcwe && m_stall < CMAX) m_stall++;
            if (e_sel && e_pcwe && m_redir < CMAX) m_redir++;
            m_wait = n_wait; m_pv = n_pv; m_pend = n_pend;
        end
    end

    task automatic step(input bit b, input bit h, input bit br, input logic [31:0] a);
        @(posedge CLK);
        #1;
        imem_busy = b; load_use_hazard = h; branch_control = br; branch_address = a;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET = 0;
        imem_busy = 0; load_use_hazard = 0; branch_control = 0; branch_address = 32'h0;
        @(negedge CLK);
        check("rst_pc_we", 32'(pc_write_en), 0);
        check("rst_if_flush", 32'(if_id_flush), 1);
        check("rst_stall", 32'(stall_cycles), 0);
        check("rst_redir_cnt", 32'(redirect_count), 0);
        @(posedge CLK);
        #1;
        RESET = 1;
    endtask

    typedef struct packed {
        logic        b, h, br;
        logic [31:0] a;
    } vec_t;

    vec_t mix[10];

    initial begin
        // Idle after reset: PC free-runs, no counts.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check("idle_pc_we", 32'(pc_write_en), 1);
        end
        check("idle_stall", 32'(stall_cycles), 0);
        check("idle_redir", 32'(redirect_count), 0);

        // Branch in RUN redirects immediately.
        do_reset();
        step(0, 0, 1, 32'h0000_0100);
        check("br_pc_sel", 32'(pc_sel), 1);
        check("br_addr", redirect_address, 32'h0000_0100);
        check("br_if_flush", 32'(if_id_flush), 1);
        check("br_ex_flush", 32'(id_ex_flush), 1);
        step(0, 0, 0, 0);
        check("br_redir_cnt", 32'(redirect_count), 1);

        // One-cycle load-use stall.
        do_reset();
        step(0, 1, 0, 0);
        check("lu_pc_we", 32'(pc_write_en), 0);
        check("lu_ifid_we", 32'(if_id_write_en), 0);
        check("lu_ex_flush", 32'(id_ex_flush), 1);
        step(0, 0, 0, 0);
        check("lu_stall", 32'(stall_cycles), 1);

        // Busy for 3 cycles with a branch parked in cycle 2.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0200);
        step(1, 0, 0, 0);
        check("hold_state", 32'(dbg_state), 32'(ST_REDIRECT_HOLD));
        check("hold_pc_we", 32'(pc_write_en), 0);
        step(0, 0, 0, 0);
        check("rel_pc_sel", 32'(pc_sel), 1);
        check("rel_addr", redirect_address, 32'h0000_0200);
        check("rel_if_flush", 32'(if_id_flush), 1);
        check("rel_stall", 32'(stall_cycles), 3);
        step(0, 0, 0, 0);
        check("rel_redir_cnt", 32'(redirect_count), 1);

        // Younger branch wins over the parked target when busy drops.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0200);
        step(1, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0300);
        check("win_pc_sel", 32'(pc_sel), 1);
        check("win_addr", redirect_address, 32'h0000_0300);
        step(0, 0, 0, 0);
        check("win_state", 32'(dbg_state), 32'(ST_RUN));
        check("win_no_redir", 32'(pc_sel), 0);

        // Saturation, then reset while a redirect is parked.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sat_stall", 32'(stall_cycles), 32'h0000_000F);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0400);
        step(1, 0, 0, 0);
        check("sat_hold_state", 32'(dbg_state), 32'(ST_REDIRECT_HOLD));
        check("sat_hold_addr", redirect_address, 32'h0000_0400);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("post_rst_pc_sel", 32'(pc_sel), 0);
            check("post_rst_redir", 32'(redirect_count), 0);
        end
        check("post_rst_state", 32'(dbg_state), 32'(ST_RUN));

        // Mixed hazard/busy/branch interleavings.
        mix[0] = '{1, 1, 0, 32'h0};
        mix[1] = '{1, 1, 0, 32'h0};
        mix[2] = '{1, 0, 0, 32'h0};
        mix[3] = '{0, 1, 0, 32'h0};
        mix[4] = '{1, 1, 1, 32'h0000_0500};
        mix[5] = '{1, 0, 0, 32'h0};
        mix[6] = '{1, 0, 1, 32'h0000_0600};
        mix[7] = '{1, 1, 1, 32'h0000_0700};
        mix[8] = '{0, 0, 0, 32'h0};
        mix[9] = '{0, 0, 0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            step(mix[i].b, mix[i].h, mix[i].br, mix[i].a);
            if (i == 8) check("mix_overwrite_addr", redirect_address, 32'h0000_0700);
        end

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
